// File: rtl/pp_iter_multiplier.sv
// ============================================================================
// Module   : pp_iter_multiplier
// Brief    : Iterative shift-and-add multiplier, PP_PER_CYC partial products/cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_iter_multiplier #(
  parameter int WIDTH      = 24,
  parameter int PP_PER_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int C_STEPS = WIDTH / PP_PER_CYC;
  localparam int C_CW    = $clog2(C_STEPS) + 1;

  generate
    if (WIDTH < 2 || PP_PER_CYC < 1 || (WIDTH % PP_PER_CYC) != 0) begin : g_param_check
      $error("pp_iter_multiplier: illegal WIDTH/PP_PER_CYC combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [C_CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_sh_q, b_sh_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_pp_sum;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the
  // correct magnitude when read back as unsigned.
  assign w_a_mag = (in_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (in_signed && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    neg_d     = neg_q;
    product_d = product_q;

    // Multiplicand is pre-shifted each step, so bit j of the shifted
    // multiplier selects a_sh << j for absolute bit counter+j.
    w_pp_sum = acc_q;
    for (int j = 0; j < PP_PER_CYC; j++) begin
      if (b_sh_q[j]) begin
        w_pp_sum = w_pp_sum + (a_sh_q << j);
      end
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d = S_CALC;
            cnt_d   = '0;
            acc_d   = '0;
            a_sh_d  = {{WIDTH{1'b0}}, w_a_mag};
            b_sh_d  = w_b_mag;
            neg_d   = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        S_CALC: begin
          acc_d  = w_pp_sum;
          a_sh_d = a_sh_q << PP_PER_CYC;
          b_sh_d = b_sh_q >> PP_PER_CYC;
          cnt_d  = cnt_q + C_CW'(1);
          if (cnt_q == C_CW'(C_STEPS - 1)) begin
            product_d = neg_q ? -w_pp_sum : w_pp_sum;
            state_d   = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign product   = product_q;

endmodule

`default_nettype wire

// File: tb/tb_pp_iter_multiplier.sv
// ============================================================================
// Module   : tb_pp_iter_multiplier
// Brief    : Directed self-checking bench for pp_iter_multiplier (PP=1 and PP=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pp_iter_multiplier;

  logic        clk;
  logic        rst_n;
  logic        abort;

  logic        in_valid1, in_ready1, in_signed1, out_valid1, out_ready1, busy1;
  logic [7:0]  a1, b1;
  logic [15:0] product1;

  logic        in_valid4, in_ready4, in_signed4, out_valid4, out_ready4, busy4;
  logic [7:0]  a4, b4;
  logic [15:0] product4;

  int checks;
  int errors;

  pp_iter_multiplier #(.WIDTH(8), .PP_PER_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_signed(in_signed1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .product(product1), .busy(busy1)
  );

  pp_iter_multiplier #(.WIDTH(8), .PP_PER_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .abort(1'b0),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_signed(in_signed4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .product(product4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand pair to dut1 for exactly one (accepting) edge.
  task automatic issue1(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    in_valid1  = 1'b1;
    a1         = av;
    b1         = bv;
    in_signed1 = sv;
    @(posedge clk); #1;
    in_valid1  = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid, bounded.
  task automatic wait1(output int cyc);
    cyc = 0;
    while (!out_valid1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic consume1();
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
    checks++; if (product1 !== 16'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", product1); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready1); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4 got %b want 1", in_ready4); end
  endtask

  task automatic test_unsigned();
    int cyc;
    issue1(8'd200, 8'd150, 1'b0);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL unsigned_busy got %b want 1", busy1); end
    wait1(cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL unsigned_latency got %0d want 8", cyc); end
    checks++; if (product1 !== 16'h7530) begin errors++; $display("FAIL unsigned_product got %h want 7530", product1); end
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL unsigned_in_ready_done got %b want 0", in_ready1); end
    consume1();
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL unsigned_after_consume got ov=%b ir=%b want ov=0 ir=1", out_valid1, in_ready1); end
    checks++; if (product1 !== 16'h7530) begin errors++; $display("FAIL unsigned_product_hold got %h want 7530", product1); end
  endtask

  task automatic test_signed();
    logic [7:0]  va [3] = '{8'h80, 8'hFD, 8'h00};
    logic [7:0]  vb [3] = '{8'h80, 8'h05, 8'hF9};
    logic [15:0] vp [3] = '{16'h4000, 16'hFFF1, 16'h0000};
    int cyc;
    for (int k = 0; k < 3; k++) begin
      issue1(va[k], vb[k], 1'b1);
      wait1(cyc);
      checks++; if (cyc !== 8) begin errors++; $display("FAIL signed_latency[%0d] got %0d want 8", k, cyc); end
      checks++; if (product1 !== vp[k]) begin errors++; $display("FAIL signed_product[%0d] got %h want %h", k, product1, vp[k]); end
      consume1();
    end
  endtask

  task automatic test_pp4();
    int cyc;
    in_valid4 = 1'b1; a4 = 8'd255; b4 = 8'd255; in_signed4 = 1'b0;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    cyc = 0;
    while (!out_valid4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL pp4_latency got %0d want 2", cyc); end
    checks++; if (product4 !== 16'hFE01) begin errors++; $display("FAIL pp4_product got %h want FE01", product4); end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL pp4_return_idle got %b want 1", in_ready4); end
  endtask

  task automatic test_backpressure();
    int cyc;
    issue1(8'd3, 8'd4, 1'b0);
    wait1(cyc);
    in_valid1 = 1'b1; a1 = 8'd1; b1 = 8'd1; in_signed1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got ov=%b ir=%b want ov=1 ir=0", k, out_valid1, in_ready1); end
      checks++; if (product1 !== 16'h000C) begin errors++; $display("FAIL bp_product[%0d] got %h want 000C", k, product1); end
    end
    in_valid1 = 1'b0;
    consume1();
    checks++; if (in_ready1 !== 1'b1 || product1 !== 16'h000C) begin errors++; $display("FAIL bp_release got ir=%b p=%h want ir=1 p=000C", in_ready1, product1); end
  endtask

  task automatic test_abort();
    int cyc;
    int seen;
    issue1(8'd100, 8'd100, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL abort_idle got busy=%b ir=%b want busy=0 ir=1", busy1, in_ready1); end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_output got %0d valid cycles want 0", seen); end
    checks++; if (product1 !== 16'h000C) begin errors++; $display("FAIL abort_product_kept got %h want 000C", product1); end
    abort = 1'b1; in_valid1 = 1'b1; a1 = 8'd5; b1 = 8'd5; in_signed1 = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; in_valid1 = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_blocks_accept got busy=%b want 0", busy1); end
    issue1(8'd12, 8'd11, 1'b0);
    wait1(cyc);
    checks++; if (cyc !== 8 || product1 !== 16'h0084) begin errors++; $display("FAIL abort_followup got cyc=%0d p=%h want cyc=8 p=0084", cyc, product1); end
    consume1();
  endtask

  task automatic test_reset_mid();
    int cyc;
    issue1(8'd50, 8'd50, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (product1 !== 16'h0000) begin errors++; $display("FAIL rstmid_product got %h want 0000", product1); end
    checks++; if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got busy=%b ov=%b want 0 0", busy1, out_valid1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue1(8'd7, 8'd9, 1'b0);
    wait1(cyc);
    checks++; if (cyc !== 8 || product1 !== 16'h003F) begin errors++; $display("FAIL rstmid_followup got cyc=%0d p=%h want cyc=8 p=003F", cyc, product1); end
    consume1();
  endtask

  initial begin
    checks = 0; errors = 0;
    abort = 1'b0;
    in_valid1 = 1'b0; in_signed1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b0;
    in_valid4 = 1'b0; in_signed4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_pp4();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pp_iter_multiplier.md
PP_ITER_MULTIPLIER -- requirements
Module: pp_iter_multiplier

Interface
REQ-001 Parameter WIDTH, default 24, operand width in bits (FP32 significand incl. hidden bit).
REQ-002 Parameter PP_PER_CYC, default 1, partial products accumulated per compute cycle.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 abort  input  1  synchronous cancel of any operation in flight.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
REQ-009 a, b  input  WIDTH each  multiplicand, multiplier.
REQ-010 out_valid  output  1  product available.
REQ-011 out_ready  input  1  consumer takes product.
REQ-012 product  output  2*WIDTH  full-precision product.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Elaboration SHALL fail unless WIDTH >= 2, PP_PER_CYC >= 1, and WIDTH mod PP_PER_CYC = 0.
REQ-015 FSM states SHALL be IDLE, CALC, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 IDLE: on in_valid=1, capture a, b, in_signed; clear accumulator and step counter; go to CALC.
REQ-017 Signed capture: store operand magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1), unsigned WIDTH bits) and neg = sign(a) XOR sign(b); unsigned: neg = 0.
REQ-018 CALC: each cycle, for j = 0..PP_PER_CYC-1 and i = counter+j, add (b_mag[i] AND a_mag) << i into the 2*WIDTH accumulator; counter += PP_PER_CYC.
REQ-019 CALC SHALL last exactly C = WIDTH/PP_PER_CYC cycles; the C-th CALC edge loads product = neg ? two's-complement negation of accumulator sum : sum, and enters DONE.
REQ-020 out_valid SHALL rise on the C-th rising edge after the accepting edge (C+1 edges counting acceptance).
REQ-021 DONE: product and out_valid held stable while out_ready=0; on out_ready=1, return to IDLE next edge.
REQ-022 in_ready and out_valid SHALL never be high in the same cycle; throughput one operation per C+2 cycles minimum.
REQ-023 Accumulator arithmetic SHALL not overflow 2*WIDTH bits; no truncation or rounding.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge, discard operands, never assert out_valid for the aborted op; abort with in_valid in IDLE SHALL not accept.
REQ-025 product SHALL change only on the DONE-entry edge or reset; the last result remains visible after leaving DONE.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, counter 0, accumulator 0, product 0, neg 0, out_valid 0, busy 0; in_ready 1 once rst_n=1.
REQ-027 Reset asserted mid-CALC or in DONE SHALL drop the operation with no output; first op after release behaves as REQ-016..021.

Verification
REQ-028 WIDTH=8, PP_PER_CYC=1, unsigned 200 x 150 -> product 0x7530, out_valid on 8th edge after acceptance.
REQ-029 WIDTH=8 signed: -128 x -128 -> 0x4000; -3 x 5 -> 0xFFF1; 0 x -7 -> 0x0000.
REQ-030 WIDTH=8, PP_PER_CYC=4, unsigned 255 x 255 -> 0xFE01 after 2 compute cycles.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> product/out_valid stable, in_ready 0; new in_valid ignored until IDLE.
REQ-032 abort at 3rd CALC cycle -> IDLE next edge, no out_valid; following 12 x 11 unsigned -> 0x0084.
REQ-033 rst_n low mid-CALC -> all outputs at reset values asynchronously; after release 7 x 9 -> 0x003F.
